// File: rtl/hours_counter_if.sv
// Hours-counter control/status bundle: tick, set-mode buttons, load, and registered outputs.
// Latency: none, wires only.
// Backpressure: none; all strobes are single-cycle pulses or levels.
interface hours_counter_if #(
  parameter int W = 7
);
  logic         tick;
  logic         set_mode;
  logic         inc_btn;
  logic         dec_btn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] hours;
  logic         pm;
  logic         day_tick;

  // Driver side: the minutes stage, the user buttons and the loader
  modport master (
    output tick, set_mode, inc_btn, dec_btn, load, load_val,
    input  hours, pm, day_tick
  );

  // Counter side
  modport slave (
    input  tick, set_mode, inc_btn, dec_btn, load, load_val,
    output hours, pm, day_tick
  );
endinterface

// File: rtl/hours_counter.sv
// Hours counter 0..HRMAX with load, set-mode inc/dec buttons and minute-rollover tick.
// Latency: 1 cycle from causing input to registered outputs; no comb input->output path.
// Backpressure: none; optional AM/PM flag built only when HOURS_AMPM_EN is defined.
module hours_counter #(
  parameter int HRMAX = 11,
  parameter int W     = 7
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  hours_counter_if.slave  bus
);

  localparam logic [W-1:0] LP_MAX  = W'(HRMAX);
  localparam logic [W-1:0] LP_ZERO = '0;
  localparam logic [W-1:0] LP_ONE  = W'(1);

  logic [W-1:0] r_hours;
  logic         r_day_tick;
  logic         r_inc_prev;
  logic         r_dec_prev;

  logic [W-1:0] w_hours_nxt;
  logic         w_day_nxt;
  logic         w_wrap;
  logic         w_inc_edge;
  logic         w_dec_edge;
  logic         w_load_ok;

  assign w_inc_edge = bus.inc_btn & ~r_inc_prev;
  assign w_dec_edge = bus.dec_btn & ~r_dec_prev;
  // Out-of-range loads are dropped so lower-priority actions still get this cycle
  assign w_load_ok  = bus.load && (bus.load_val <= LP_MAX);

  // Next-state: load beats set-mode buttons beats tick; at most one action per cycle
  always_comb begin
    w_hours_nxt = r_hours;
    w_day_nxt   = 1'b0;
    w_wrap      = 1'b0;
    if (w_load_ok) begin
      w_hours_nxt = bus.load_val;
    end else if (bus.set_mode) begin
      // Tick is swallowed while the user is adjusting; opposing edges cancel
      if (w_inc_edge && !w_dec_edge) begin
        if (r_hours == LP_MAX) begin
          w_hours_nxt = LP_ZERO;
          w_wrap      = 1'b1;
        end else begin
          w_hours_nxt = r_hours + LP_ONE;
        end
      end else if (w_dec_edge && !w_inc_edge) begin
        if (r_hours == LP_ZERO) begin
          w_hours_nxt = LP_MAX;
          w_wrap      = 1'b1;
        end else begin
          w_hours_nxt = r_hours - LP_ONE;
        end
      end
    end else if (bus.tick) begin
      if (r_hours == LP_MAX) begin
        w_hours_nxt = LP_ZERO;
        w_wrap      = 1'b1;
        w_day_nxt   = 1'b1;
      end else begin
        w_hours_nxt = r_hours + LP_ONE;
      end
    end
  end

  // Hour count, day pulse and button history; history samples every cycle in any mode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hours    <= LP_ZERO;
      r_day_tick <= 1'b0;
      r_inc_prev <= 1'b0;
      r_dec_prev <= 1'b0;
    end else begin
      r_hours    <= w_hours_nxt;
      r_day_tick <= w_day_nxt;
      r_inc_prev <= bus.inc_btn;
      r_dec_prev <= bus.dec_btn;
    end
  end

  assign bus.hours    = r_hours;
  assign bus.day_tick = r_day_tick;

`ifdef HOURS_AMPM_EN
  logic r_pm;

  // AM/PM flips on any wrap, up or down, tick or button; loads never touch it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pm <= 1'b0;
    end else if (w_wrap) begin
      r_pm <= ~r_pm;
    end
  end

  assign bus.pm = r_pm;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_wrap;
  assign bus.pm        = 1'b0;
`endif

endmodule

// File: tb/tb_hours_counter.sv
// Directed bench for hours_counter (HRMAX=11, W=7); expected pm follows HOURS_AMPM_EN.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// No backpressure; every step is a fixed cycle count so the run always terminates.
module tb_hours_counter;
`ifdef HOURS_AMPM_EN
  localparam bit AMPM = 1'b1;
`else
  localparam bit AMPM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  logic m_pm = 1'b0;  // hand-tracked AM/PM state, used only when AMPM is built

  hours_counter_if #(.W(7)) u_if ();

  hours_counter #(.HRMAX(11), .W(7)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    u_if.tick = 0; u_if.set_mode = 0; u_if.inc_btn = 0; u_if.dec_btn = 0;
    u_if.load = 0; u_if.load_val = '0;
    rst_n = 0;
    #12;
    n_run++; if (u_if.hours !== 7'd0) begin n_fail++; $display("FAIL reset_hours got=%0d exp=0", u_if.hours); end
    n_run++; if (u_if.pm !== 1'b0) begin n_fail++; $display("FAIL reset_pm got=%b exp=0", u_if.pm); end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL reset_day_tick got=%b exp=0", u_if.day_tick); end
    cyc();
    rst_n = 1;
  endtask

  task automatic test_tick_wrap();
    for (int i = 1; i <= 11; i++) begin
      u_if.tick = 1; cyc(); u_if.tick = 0;
      n_run++; if (u_if.hours !== 7'(i)) begin n_fail++; $display("FAIL tick_count got=%0d exp=%0d", u_if.hours, i); end
    end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL tick_11_day got=%b exp=0", u_if.day_tick); end
    n_run++; if (u_if.pm !== 1'b0) begin n_fail++; $display("FAIL tick_11_pm got=%b exp=0", u_if.pm); end
    u_if.tick = 1; cyc(); u_if.tick = 0;
    m_pm = ~m_pm;
    n_run++; if (u_if.hours !== 7'd0) begin n_fail++; $display("FAIL tick_wrap_hours got=%0d exp=0", u_if.hours); end
    n_run++; if (u_if.day_tick !== 1'b1) begin n_fail++; $display("FAIL tick_wrap_day got=%b exp=1", u_if.day_tick); end
    n_run++; if (u_if.pm !== (AMPM & m_pm)) begin n_fail++; $display("FAIL tick_wrap_pm got=%b exp=%b", u_if.pm, AMPM & m_pm); end
    cyc();
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL day_pulse_width got=%b exp=0", u_if.day_tick); end
    n_run++; if (u_if.hours !== 7'd0) begin n_fail++; $display("FAIL hold_after_wrap got=%0d exp=0", u_if.hours); end
  endtask

  task automatic test_dec_button();
    u_if.set_mode = 1; u_if.dec_btn = 1; cyc();
    m_pm = ~m_pm;
    n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL dec_wrap_hours got=%0d exp=11", u_if.hours); end
    n_run++; if (u_if.pm !== (AMPM & m_pm)) begin n_fail++; $display("FAIL dec_wrap_pm got=%b exp=%b", u_if.pm, AMPM & m_pm); end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL dec_wrap_day got=%b exp=0", u_if.day_tick); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL dec_held got=%0d exp=11 cycle=%0d", u_if.hours, i); end
    end
    u_if.dec_btn = 0; cyc();
    u_if.dec_btn = 1; cyc();
    n_run++; if (u_if.hours !== 7'd10) begin n_fail++; $display("FAIL dec_plain got=%0d exp=10", u_if.hours); end
    u_if.dec_btn = 0; u_if.inc_btn = 1; cyc(); u_if.inc_btn = 0; cyc();
    n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL inc_plain got=%0d exp=11", u_if.hours); end
  endtask

  task automatic test_simultaneous();
    u_if.inc_btn = 1; u_if.dec_btn = 1; cyc();
    n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL inc_dec_same got=%0d exp=11", u_if.hours); end
    u_if.inc_btn = 0; u_if.dec_btn = 0; cyc();
    u_if.tick = 1; cyc(); u_if.tick = 0;
    n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL tick_in_set got=%0d exp=11", u_if.hours); end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL tick_in_set_day got=%b exp=0", u_if.day_tick); end
    cyc();
    n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL tick_not_replayed got=%0d exp=11", u_if.hours); end
    u_if.inc_btn = 1; cyc();
    m_pm = ~m_pm;
    n_run++; if (u_if.hours !== 7'd0) begin n_fail++; $display("FAIL inc_wrap_hours got=%0d exp=0", u_if.hours); end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL inc_wrap_day got=%b exp=0", u_if.day_tick); end
    n_run++; if (u_if.pm !== (AMPM & m_pm)) begin n_fail++; $display("FAIL inc_wrap_pm got=%b exp=%b", u_if.pm, AMPM & m_pm); end
    u_if.inc_btn = 0; cyc();
  endtask

  task automatic test_load();
    u_if.set_mode = 0;
    u_if.load = 1; u_if.load_val = 7'd7; u_if.tick = 1; cyc();
    n_run++; if (u_if.hours !== 7'd7) begin n_fail++; $display("FAIL load7_hours got=%0d exp=7", u_if.hours); end
    n_run++; if (u_if.pm !== (AMPM & m_pm)) begin n_fail++; $display("FAIL load7_pm got=%b exp=%b", u_if.pm, AMPM & m_pm); end
    u_if.load_val = 7'd13; cyc();
    n_run++; if (u_if.hours !== 7'd8) begin n_fail++; $display("FAIL load13_ignored got=%0d exp=8", u_if.hours); end
    u_if.load_val = 7'd11; cyc();
    n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL load11_hours got=%0d exp=11", u_if.hours); end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL load_day got=%b exp=0", u_if.day_tick); end
    u_if.load = 0; u_if.load_val = '0; cyc();
    u_if.tick = 0;
    m_pm = ~m_pm;
    n_run++; if (u_if.hours !== 7'd0) begin n_fail++; $display("FAIL after_load_wrap got=%0d exp=0", u_if.hours); end
    n_run++; if (u_if.day_tick !== 1'b1) begin n_fail++; $display("FAIL after_load_day got=%b exp=1", u_if.day_tick); end
    n_run++; if (u_if.pm !== (AMPM & m_pm)) begin n_fail++; $display("FAIL after_load_pm got=%b exp=%b", u_if.pm, AMPM & m_pm); end
    u_if.load = 1; u_if.load_val = 7'd0; cyc(); u_if.load = 0;
    n_run++; if (u_if.pm !== (AMPM & m_pm)) begin n_fail++; $display("FAIL load0_pm got=%b exp=%b", u_if.pm, AMPM & m_pm); end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL load0_day got=%b exp=0", u_if.day_tick); end
  endtask

  task automatic test_reset_mid();
    u_if.load = 1; u_if.load_val = 7'd11; cyc(); u_if.load = 0;
    u_if.tick = 1; cyc(); u_if.tick = 0;
    n_run++; if (u_if.day_tick !== 1'b1) begin n_fail++; $display("FAIL pre_rst_day got=%b exp=1", u_if.day_tick); end
    #2 rst_n = 0;
    #1;
    m_pm = 1'b0;
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL rst_in_day got=%b exp=0", u_if.day_tick); end
    n_run++; if (u_if.pm !== 1'b0) begin n_fail++; $display("FAIL rst_in_day_pm got=%b exp=0", u_if.pm); end
    cyc();
    rst_n = 1;
    u_if.load = 1; u_if.load_val = 7'd11; cyc(); u_if.load = 0;
    n_run++; if (u_if.hours !== 7'd11) begin n_fail++; $display("FAIL reload11 got=%0d exp=11", u_if.hours); end
    u_if.tick = 1;
    #3 rst_n = 0;
    #1;
    n_run++; if (u_if.hours !== 7'd0) begin n_fail++; $display("FAIL async_rst_hours got=%0d exp=0", u_if.hours); end
    n_run++; if (u_if.pm !== 1'b0) begin n_fail++; $display("FAIL async_rst_pm got=%b exp=0", u_if.pm); end
    u_if.tick = 0;
    cyc();
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL in_rst_day got=%b exp=0", u_if.day_tick); end
    u_if.set_mode = 1; u_if.inc_btn = 1;
    cyc();
    rst_n = 1;
    cyc();
    n_run++; if (u_if.hours !== 7'd1) begin n_fail++; $display("FAIL held_btn_release got=%0d exp=1", u_if.hours); end
    n_run++; if (u_if.day_tick !== 1'b0) begin n_fail++; $display("FAIL release_day got=%b exp=0", u_if.day_tick); end
    n_run++; if (u_if.pm !== 1'b0) begin n_fail++; $display("FAIL release_pm got=%b exp=0", u_if.pm); end
    cyc();
    n_run++; if (u_if.hours !== 7'd1) begin n_fail++; $display("FAIL held_btn_once got=%0d exp=1", u_if.hours); end
    u_if.inc_btn = 0; u_if.set_mode = 0; cyc();
  endtask

  initial begin
    test_reset();
    test_tick_wrap();
    test_dec_button();
    test_simultaneous();
    test_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hours_counter.md
HOURS_COUNTER -- requirements
Module: hours_counter

Interface
REQ-001 Parameter HRMAX, default 11: highest hour count; hours count 0..HRMAX, and the downstream 0-to-12 display mapping handles 0.
REQ-002 Parameter W, default 7: width of the hour count and load value; HRMAX SHALL fit in W bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-cycle pulse from the minutes stage at minute 59->0 rollover.
REQ-006 set_mode  input  1  level; high = user is adjusting hours.
REQ-007 inc_btn  input  1  synchronized, debounced level; a rising edge increments the count in set mode.
REQ-008 dec_btn  input  1  synchronized, debounced level; a rising edge decrements the count in set mode.
REQ-009 load  input  1  one-cycle strobe: load load_val.
REQ-010 load_val  input  W  value to load.
REQ-011 hours  output  W  registered hour count 0..HRMAX; feeds the display-mapping stage.
REQ-012 pm  output  1  registered AM/PM flag (present only per REQ-030).
REQ-013 day_tick  output  1  registered one-cycle pulse on a tick-driven wrap.

Function
REQ-014 Priority each cycle SHALL be: load > set-mode button action > tick; at most one action per cycle.
REQ-015 load with load_val<=HRMAX SHALL set hours=load_val next edge, leave pm unchanged, no day_tick.
REQ-016 load with load_val>HRMAX SHALL be ignored; the cycle then falls through to lower-priority actions.
REQ-017 Edge detect: previous-level registers for inc_btn and dec_btn SHALL update every cycle regardless of mode; a rising edge = current 1 and previous 0.
REQ-018 In set mode, an inc edge alone SHALL increment hours; at HRMAX it wraps to 0.
REQ-019 In set mode, a dec edge alone SHALL decrement hours; at 0 it wraps to HRMAX.
REQ-020 Simultaneous inc and dec edges SHALL leave hours unchanged.
REQ-021 While set_mode=1, tick SHALL be ignored; a lost tick is not replayed.
REQ-022 When set_mode=0 and tick=1, hours SHALL increment; at HRMAX it wraps to 0.
REQ-023 Latency: the hours change is visible on the edge that samples the causing input (1 cycle); no combinational path from inputs to outputs.
REQ-024 day_tick SHALL be 1 for exactly the one cycle in which hours first shows 0 after a tick-driven wrap; manual and load changes never assert it.
REQ-025 Outputs SHALL hold between events; hours never leaves 0..HRMAX.

Reset
REQ-026 rst_n low SHALL asynchronously force hours=0, pm=0, day_tick=0, and both button-history registers=0.
REQ-027 Release of rst_n is synchronous to clk; the first action occurs on the first edge with rst_n high.
REQ-028 Reset mid-operation (including during a day_tick cycle or a held button) SHALL clear all state; a button held through reset release counts as a rising edge on the first active edge where it is sampled high.
REQ-029 After reset, hours=0 is displayed as 12 AM by the downstream stage.

Configuration
REQ-030 Macro HOURS_AMPM_EN: when defined, pm SHALL exist and toggle on every wrap in either direction (HRMAX->0 or 0->HRMAX, from tick or button); load leaves it unchanged.
REQ-031 Without HOURS_AMPM_EN, the pm port SHALL be tied to 0 and no pm register is built; all other behaviour is identical.

Verification
REQ-032 Reset, then 11 ticks (set_mode=0) -> hours=11, pm=0; 12th tick -> hours=0, pm=1, day_tick high for exactly 1 cycle.
REQ-033 set_mode=1, hours=0, one dec_btn rising edge -> hours=11, pm toggles, day_tick=0; holding dec_btn high 5 cycles -> no further change.
REQ-034 set_mode=1, inc and dec edges in the same cycle -> hours unchanged; tick in set mode -> hours unchanged.
REQ-035 load=1 with load_val=7 and simultaneous tick -> hours=7 only; load_val=13 with tick -> load ignored, hours increments by 1.
REQ-036 hours=11, tick, and rst_n asserted asynchronously mid-cycle -> outputs 0 immediately, no day_tick after release; repeat the run without HOURS_AMPM_EN -> pm stays 0 throughout.
